bisr_output_merge_os: RTL and testbench
=======================================

Name: bisr_output_merge_os

Overview:
- Downstream stage of the output-stationary BISR top level.
- Captures the ROWS drained result rows from the systolic array's bottom output bus into a ROWSxCOLS result buffer.
- Overwrites cells computed by faulty PEs with recompute-unit (RU) results, using each RU's row/column coordinates.
- Streams the corrected matrix out row by row over a valid/ready handshake.

Parameters:
- ROWS, 4, systolic array rows (number of drained output rows)
- COLS, 4, systolic array columns
- WORD_SIZE, 16, bits per result word
- NUM_RU, 4, number of recompute units

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (all state clears on the clk edge where rst=0)
- start  in  1  pulse; begins a matrix; honoured only in IDLE
- ru_active  in  NUM_RU  RUs expected to deliver a patch this matrix; sampled on accepted start
- drain_valid  in  1  systolic_bottom_out holds the next drained row
- systolic_bottom_out  in  COLS*WORD_SIZE  drained row; word c at [c*WORD_SIZE +: WORD_SIZE]
- ru_output_valid  in  NUM_RU  per-RU result valid
- rcm_bottom_out  in  NUM_RU*WORD_SIZE  per-RU result word
- ru_col_mapping  in  $clog2(COLS)*NUM_RU  per-RU target column
- ru_row_mapping  in  $clog2(COLS)*NUM_RU  per-RU target row (field width matches the upstream bus)
- out_valid  out  1  out_row_data valid
- out_ready  in  1  consumer accepts the row
- out_row_data  out  COLS*WORD_SIZE  corrected row
- out_row_idx  out  $clog2(ROWS)  index of the row on out_row_data
- out_last  out  1  high with the final row
- busy  out  1  high whenever not in IDLE

Behaviour:
- Reset values: out_valid=0, out_row_data=0, out_row_idx=0, out_last=0, busy=0. Buffer, patched mask, RU-done mask and counters all clear.
- Reset mid-operation aborts the current matrix immediately, with no further output.
- FSM states: IDLE, CAPTURE, PATCH_WAIT, STREAM.
- IDLE -> CAPTURE on start:
  - latch ru_active into expect mask;
  - clear patched mask, done mask and row counter.
- CAPTURE: each cycle with drain_valid=1:
  - write word c into buf[cap_row][c], except cells whose patched bit is set;
  - increment cap_row;
  - after row ROWS-1 is written, go to PATCH_WAIT.
- Patch accept (CAPTURE and PATCH_WAIT only): RU i is accepted when ru_output_valid[i]=1, expect[i]=1 and done[i]=0. On accept:
  - buf[row_i][col_i] = rcm word i;
  - set patched[row_i][col_i] and done[i].
- Patch conflicts and ignored patches:
  - A patch beats a capture to the same cell, in the same cycle or any later cycle.
  - Two RUs hitting one cell in the same cycle: the higher RU index wins; both are marked done.
  - row_i >= ROWS or col_i >= COLS: the RU is marked done and nothing is written.
  - ru_output_valid outside CAPTURE/PATCH_WAIT, or for a non-expected RU, is ignored.
- PATCH_WAIT -> STREAM when (done & expect) == expect. With expect=0 this takes one cycle.
- STREAM:
  - row r presented registered: out_valid=1, out_row_idx=r, out_last=(r==ROWS-1);
  - row r+1 is presented the cycle after a handshake (out_valid & out_ready);
  - data stays stable while out_ready=0;
  - the handshake on the last row returns to IDLE with out_valid=0 the next cycle.
- start while busy is ignored.
- Latency: the first out_valid appears 2 cycles after the final drain row when no patches are pending.

Optional Feature:
- Macro: BISR_MERGE_PATCH_STATS_EN.
- Defined:
  - adds output patch_count [$clog2(ROWS*COLS+1)-1:0], counting cells written by patches since reset;
  - saturates at its maximum;
  - counts same-cell multi-RU patches once;
  - cleared only by rst.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header:
  - FSM state encodings;
  - localparams ROW_W=$clog2(ROWS), MAP_W=$clog2(COLS), CNT_W;
  - helpers extracting RU field i from the packed buses.
- One sub-module, bisr_patch_arbiter: combinational per-cell write enable and data from the NUM_RU inputs, with higher index taking priority.
- Buffer, FSM and streaming stay in the top.

Test Plan (ROWS=COLS=4, WORD_SIZE=16, NUM_RU=4):
- No faults: start with ru_active=0, drain rows {r*16+c}, out_ready=1 -> 4 rows out unchanged, out_last on row 3, busy falls the cycle after.
- Single patch after capture: ru_active=0001, RU0 row=2 col=1 data=0xBEEF after drain -> row 2 word 1 = 0xBEEF, all other words unchanged; no out_valid before the patch.
- Early patch: RU1 (1,3)=0x1234 arrives before row 1 is drained -> the drained value is discarded and 0x1234 is output.
- Collision: RU0 and RU2 both target (0,0) in the same cycle, data 0x1111/0x2222, ru_active=0101 -> 0x2222; STREAM entered.
- Backpressure: out_ready low 3 cycles on row 1 -> out_row_data/out_row_idx stable; 4 handshakes total; start during STREAM ignored.
- Reset mid-CAPTURE: rst=0 after 2 rows -> the next cycle all outputs are 0 and busy=0; a fresh matrix then completes correctly. With the macro defined, patch_count=0 after reset.

Source files
------------

// File: rtl/bisr_output_merge_os_pkg.sv
// Shared types, array geometry and bus-field helpers for the BISR output merge stage.
package bisr_output_merge_os_pkg;

  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int WORD_SIZE = 16;
  localparam int NUM_RU    = 4;

  localparam int ROW_W = $clog2(ROWS);
  localparam int MAP_W = $clog2(COLS);
  localparam int CNT_W = $clog2(ROWS * COLS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_PATCH_WAIT,
    ST_STREAM
  } state_e;

  typedef logic [WORD_SIZE-1:0]            word_t;
  typedef logic [MAP_W-1:0]                map_t;
  typedef logic [COLS-1:0][WORD_SIZE-1:0]  row_t;

  function automatic word_t ru_word(input logic [NUM_RU*WORD_SIZE-1:0] bus, input int i);
    return bus[i*WORD_SIZE +: WORD_SIZE];
  endfunction

  function automatic map_t ru_map(input logic [NUM_RU*MAP_W-1:0] bus, input int i);
    return bus[i*MAP_W +: MAP_W];
  endfunction

  // Mapping fields are sized for columns, so rows are range-checked explicitly.
  function automatic logic in_range(input map_t row, input map_t col);
    return ({1'b0, row} < (MAP_W+1)'(ROWS)) && ({1'b0, col} < (MAP_W+1)'(COLS));
  endfunction

endpackage

// File: rtl/bisr_output_merge_os_if.sv
// Row-streaming valid/ready bus carrying the corrected matrix out of the merge stage.
interface bisr_output_merge_os_if;
  import bisr_output_merge_os_pkg::*;

  logic                      out_valid;
  logic                      out_ready;
  logic [COLS*WORD_SIZE-1:0] out_row_data;
  logic [ROW_W-1:0]          out_row_idx;
  logic                      out_last;

  modport master (output out_valid, out_row_data, out_row_idx, out_last, input out_ready);
  modport slave  (input out_valid, out_row_data, out_row_idx, out_last, output out_ready);
endinterface

// File: rtl/bisr_output_merge_os_patch_arbiter.sv
// Resolves accepted RU patches into per-cell write enables and data; higher RU index wins.
module bisr_patch_arbiter
  import bisr_output_merge_os_pkg::*;
(
  input  logic [NUM_RU-1:0]           accept,
  input  logic [NUM_RU*MAP_W-1:0]     ru_row_mapping,
  input  logic [NUM_RU*MAP_W-1:0]     ru_col_mapping,
  input  logic [NUM_RU*WORD_SIZE-1:0] rcm_bottom_out,
  output logic [ROWS-1:0][COLS-1:0]   cell_we,
  output row_t [ROWS-1:0]             cell_data
);

  always_comb begin
    // NOTE: outputs get a default before any conditional write so no latch is inferred.
    cell_we   = '0;
    cell_data = '0;
    for (int i = 0; i < NUM_RU; i++) begin
      map_t r;
      map_t c;
      r = ru_map(ru_row_mapping, i);
      c = ru_map(ru_col_mapping, i);
      if (accept[i] && in_range(r, c)) begin
        cell_we[ROW_W'(r)][c]   = 1'b1;
        cell_data[ROW_W'(r)][c] = ru_word(rcm_bottom_out, i);
      end
    end
  end

endmodule

// File: rtl/bisr_output_merge_os.sv
// Captures drained rows, overlays recompute-unit patches and streams the corrected matrix.
// Optional patch_count statistics output is enabled with BISR_MERGE_PATCH_STATS_EN.
module bisr_output_merge_os
  import bisr_output_merge_os_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_RU-1:0]         ru_active,
  input  logic                      drain_valid,
  input  logic [COLS*WORD_SIZE-1:0] systolic_bottom_out,
  input  logic [NUM_RU-1:0]         ru_output_valid,
  input  logic [NUM_RU*WORD_SIZE-1:0] rcm_bottom_out,
  input  logic [MAP_W*NUM_RU-1:0]   ru_col_mapping,
  input  logic [MAP_W*NUM_RU-1:0]   ru_row_mapping,
  bisr_output_merge_os_if.master    out_if,
  output logic                      busy
`ifdef BISR_MERGE_PATCH_STATS_EN
  ,
  output logic [CNT_W-1:0]          patch_count
`endif
);

  state_e                   state_q, state_d;
  logic [NUM_RU-1:0]        expect_q, expect_d;
  logic [NUM_RU-1:0]        done_q, done_d;
  logic [ROWS-1:0][COLS-1:0] patched_q, patched_d;
  row_t                     buf_q [ROWS];
  row_t                     buf_d [ROWS];
  logic [ROW_W-1:0]         cap_row_q, cap_row_d;
  logic                     out_valid_q, out_valid_d;
  row_t                     out_row_data_q, out_row_data_d;
  logic [ROW_W-1:0]         out_row_idx_q, out_row_idx_d;
  logic                     out_last_q, out_last_d;

  logic                      patch_phase;
  logic [NUM_RU-1:0]         accept;
  logic [ROWS-1:0][COLS-1:0] cell_we;
  row_t [ROWS-1:0]           cell_data;
  row_t                      drain_row;
  logic [ROW_W-1:0]          nxt_row;

  assign patch_phase = (state_q == ST_CAPTURE) || (state_q == ST_PATCH_WAIT);
  assign accept      = patch_phase ? (ru_output_valid & expect_q & ~done_q) : '0;
  assign drain_row   = row_t'(systolic_bottom_out);
  assign nxt_row     = out_row_idx_q + 1'b1;

  bisr_patch_arbiter u_arbiter (
    .accept         (accept),
    .ru_row_mapping (ru_row_mapping),
    .ru_col_mapping (ru_col_mapping),
    .rcm_bottom_out (rcm_bottom_out),
    .cell_we        (cell_we),
    .cell_data      (cell_data)
  );

  always_comb begin
    state_d        = state_q;
    expect_d       = expect_q;
    patched_d      = patched_q;
    buf_d          = buf_q;
    cap_row_d      = cap_row_q;
    out_valid_d    = out_valid_q;
    out_row_data_d = out_row_data_q;
    out_row_idx_d  = out_row_idx_q;
    out_last_d     = out_last_q;
    // Out-of-range patches still retire their RU; they just write no cell.
    done_d         = done_q | accept;

    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (cell_we[r][c]) begin
          buf_d[r][c]     = cell_data[r][c];
          patched_d[r][c] = 1'b1;
        end
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CAPTURE;
          expect_d  = ru_active;
          patched_d = '0;
          done_d    = '0;
          cap_row_d = '0;
        end
      end
      ST_CAPTURE: begin
        if (drain_valid) begin
          // A patch owns its cell whether it landed earlier or in this same cycle.
          for (int c = 0; c < COLS; c++) begin
            if (!patched_q[cap_row_q][c] && !cell_we[cap_row_q][c]) begin
              buf_d[cap_row_q][c] = drain_row[c];
            end
          end
          cap_row_d = cap_row_q + 1'b1;
          if (cap_row_q == ROW_W'(ROWS - 1)) state_d = ST_PATCH_WAIT;
        end
      end
      ST_PATCH_WAIT: begin
        if ((done_q & expect_q) == expect_q) begin
          state_d        = ST_STREAM;
          out_valid_d    = 1'b1;
          out_row_idx_d  = '0;
          out_row_data_d = buf_q[0];
          out_last_d     = (ROWS == 1);
        end
      end
      ST_STREAM: begin
        if (out_valid_q && out_if.out_ready) begin
          if (out_last_q) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            out_row_idx_d  = nxt_row;
            out_row_data_d = buf_q[nxt_row];
            out_last_d     = (nxt_row == ROW_W'(ROWS - 1));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      expect_q       <= '0;
      done_q         <= '0;
      patched_q      <= '0;
      cap_row_q      <= '0;
      out_valid_q    <= 1'b0;
      out_row_data_q <= '0;
      out_row_idx_q  <= '0;
      out_last_q     <= 1'b0;
      // NOTE: the result buffer is small and must read back as zero after reset, so it is cleared here rather than left as an unreset RAM.
      for (int r = 0; r < ROWS; r++) buf_q[r] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q        <= state_d;
      expect_q       <= expect_d;
      done_q         <= done_d;
      patched_q      <= patched_d;
      cap_row_q      <= cap_row_d;
      out_valid_q    <= out_valid_d;
      out_row_data_q <= out_row_data_d;
      out_row_idx_q  <= out_row_idx_d;
      out_last_q     <= out_last_d;
      for (int r = 0; r < ROWS; r++) buf_q[r] <= buf_d[r];
    end
  end

  assign out_if.out_valid    = out_valid_q;
  assign out_if.out_row_data = out_row_data_q;
  assign out_if.out_row_idx  = out_row_idx_q;
  assign out_if.out_last     = out_last_q;
  assign busy                = (state_q != ST_IDLE);

`ifdef BISR_MERGE_PATCH_STATS_EN
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic [CNT_W-1:0] patch_count_q, patch_count_d;

  // Cell enables are already one-hot per cell, so a multi-RU collision counts once.
  always_comb begin
    int unsigned total;
    total = 32'(patch_count_q);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        total = total + 32'(cell_we[r][c]);
      end
    end
    patch_count_d = (total > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(total);
  end

  always_ff @(posedge clk) begin
    if (!rst) patch_count_q <= '0;
    else      patch_count_q <= patch_count_d;
  end

  assign patch_count = patch_count_q;
`endif

endmodule

// File: tb/tb_bisr_output_merge_os.sv
// Directed, table-driven bench for bisr_output_merge_os (4x4 array, 16-bit words, 4 RUs).
module tb_bisr_output_merge_os;
  import bisr_output_merge_os_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  ru_active;
  logic        drain_valid;
  logic [63:0] systolic_bottom_out;
  logic [3:0]  ru_output_valid;
  logic [63:0] rcm_bottom_out;
  logic [7:0]  ru_col_mapping;
  logic [7:0]  ru_row_mapping;
  logic        busy;
`ifdef BISR_MERGE_PATCH_STATS_EN
  logic [CNT_W-1:0] patch_count;
`endif

  bisr_output_merge_os_if out_if ();

  always #5 clk = ~clk;

  bisr_output_merge_os dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .ru_active           (ru_active),
    .drain_valid         (drain_valid),
    .systolic_bottom_out (systolic_bottom_out),
    .ru_output_valid     (ru_output_valid),
    .rcm_bottom_out      (rcm_bottom_out),
    .ru_col_mapping      (ru_col_mapping),
    .ru_row_mapping      (ru_row_mapping),
    .out_if              (out_if),
    .busy                (busy)
`ifdef BISR_MERGE_PATCH_STATS_EN
    ,
    .patch_count         (patch_count)
`endif
  );

  // One matrix run: patch stimulus, when it fires, and the cells it must change.
  typedef struct {
    string       name;
    logic [3:0]  active;
    logic [3:0]  valid;
    logic [7:0]  rows;
    logic [7:0]  cols;
    logic [63:0] data;
    int          patch_at;  // -1 none, 0..3 before that drain row, 4 after capture
    bit          same;      // patch shares the cycle of drain row patch_at
    bit          refire;    // RUs fire again with inverted data once retired
    int          ov_n;
    logic [7:0]  ov_r;
    logic [7:0]  ov_c;
    logic [63:0] ov_v;
    int          bp_row;    // row held with out_ready low for 3 cycles, -1 none
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          patch_total = 0;
  logic [63:0] exp_rows [4];
  vec_t        vecs [9];

  function automatic vec_t mk(string name, logic [3:0] active, logic [3:0] valid,
                              logic [7:0] rows, logic [7:0] cols, logic [63:0] data,
                              int patch_at, bit same, bit refire, int ov_n,
                              logic [7:0] ov_r, logic [7:0] ov_c, logic [63:0] ov_v, int bp_row);
    vec_t v;
    v.name = name; v.active = active; v.valid = valid; v.rows = rows; v.cols = cols;
    v.data = data; v.patch_at = patch_at; v.same = same; v.refire = refire;
    v.ov_n = ov_n; v.ov_r = ov_r; v.ov_c = ov_c; v.ov_v = ov_v; v.bp_row = bp_row;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [63:0] drain_word_row(input int r);
    logic [63:0] w;
    for (int c = 0; c < 4; c++) w[c*16 +: 16] = 16'(r * 16 + c);
    return w;
  endfunction

  task automatic build_expected(input vec_t v);
    for (int r = 0; r < 4; r++) exp_rows[r] = drain_word_row(r);
    for (int i = 0; i < v.ov_n; i++) begin
      exp_rows[int'(v.ov_r[2*i +: 2])][int'(v.ov_c[2*i +: 2])*16 +: 16] = v.ov_v[16*i +: 16];
    end
  endtask

  task automatic drive_patch(input vec_t v, input bit flip);
    ru_output_valid = v.valid;
    ru_row_mapping  = v.rows;
    ru_col_mapping  = v.cols;
    rcm_bottom_out  = flip ? ~v.data : v.data;
  endtask

  task automatic clear_patch();
    ru_output_valid = '0;
    ru_row_mapping  = '0;
    ru_col_mapping  = '0;
    rcm_bottom_out  = '0;
  endtask

  task automatic collect(input vec_t v);
    int          cnt = 0;
    int          budget = 0;
    bit          stalled = 0;
    logic [63:0] held;
    out_if.out_ready = 1'b1;
    while (cnt < 4 && budget < 40) begin
      if (out_if.out_valid) begin
        if (v.bp_row == cnt && !stalled) begin
          stalled = 1;
          out_if.out_ready = 1'b0;
          held = out_if.out_row_data;
          for (int k = 0; k < 3; k++) begin
            start     = (k == 1);
            ru_active = (k == 1) ? 4'hF : 4'h0;
            tick();
            check($sformatf("%s stall%0d data", v.name, k), out_if.out_row_data, held);
            check($sformatf("%s stall%0d idx", v.name, k), out_if.out_row_idx, cnt);
            check($sformatf("%s stall%0d valid", v.name, k), out_if.out_valid, 1);
          end
          start = 1'b0;
          ru_active = '0;
          out_if.out_ready = 1'b1;
        end
        check($sformatf("%s row%0d data", v.name, cnt), out_if.out_row_data, exp_rows[cnt]);
        check($sformatf("%s row%0d idx", v.name, cnt), out_if.out_row_idx, cnt);
        check($sformatf("%s row%0d last", v.name, cnt), out_if.out_last, (cnt == 3));
        cnt++;
      end
      tick();
      budget++;
    end
    check($sformatf("%s rows_seen", v.name), cnt, 4);
    check($sformatf("%s end valid", v.name), out_if.out_valid, 0);
    check($sformatf("%s end busy", v.name), busy, 0);
    tick();
    check($sformatf("%s idle busy", v.name), busy, 0);
  endtask

  task automatic run_matrix(input vec_t v);
    build_expected(v);
    start = 1'b1;
    ru_active = v.active;
    tick();
    start = 1'b0;
    ru_active = '0;
    check($sformatf("%s busy", v.name), busy, 1);
    for (int r = 0; r < 4; r++) begin
      if (v.patch_at == r && !v.same) begin
        drive_patch(v, 0);
        tick();
        clear_patch();
      end
      drain_valid = 1'b1;
      systolic_bottom_out = drain_word_row(r);
      if (v.patch_at == r && v.same) drive_patch(v, 0);
      tick();
      drain_valid = 1'b0;
      clear_patch();
    end
    if (v.patch_at < 4) begin
      check($sformatf("%s lat pre", v.name), out_if.out_valid, 0);
      tick();
      check($sformatf("%s lat valid", v.name), out_if.out_valid, 1);
    end else begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("%s wait%0d valid", v.name, k), out_if.out_valid, 0);
        tick();
      end
      drive_patch(v, 0);
      tick();
      clear_patch();
      if (v.refire) begin
        drive_patch(v, 1);
        tick();
        clear_patch();
      end
    end
    collect(v);
    patch_total += v.ov_n;
`ifdef BISR_MERGE_PATCH_STATS_EN
    check($sformatf("%s patch_count", v.name), patch_count, patch_total);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk("no_fault", 4'h0, 4'h0, 8'h00, 8'h00, 64'h0, -1, 0, 0, 0, 8'h00, 8'h00, 64'h0, -1);
    vecs[1] = mk("late_patch", 4'h1, 4'h1, 8'h02, 8'h01, 64'hBEEF, 4, 0, 0,
                 1, 8'h02, 8'h01, 64'hBEEF, -1);
    vecs[2] = mk("early_patch", 4'h2, 4'h2, 8'h04, 8'h0C, 64'h0000_0000_1234_0000, 1, 0, 0,
                 1, 8'h01, 8'h03, 64'h1234, -1);
    vecs[3] = mk("collision", 4'h5, 4'h5, 8'h00, 8'h00, 64'h0000_2222_0000_1111, 4, 0, 0,
                 1, 8'h00, 8'h00, 64'h2222, -1);
    vecs[4] = mk("same_cycle", 4'h8, 4'h8, 8'hC0, 8'h80, 64'hCAFE_0000_0000_0000, 3, 1, 0,
                 1, 8'h03, 8'h02, 64'hCAFE, -1);
    vecs[5] = mk("four_ru", 4'hF, 4'hF, 8'hE4, 8'h63, 64'hA003_A002_A001_A000, 4, 0, 0,
                 4, 8'hE4, 8'h63, 64'hA003_A002_A001_A000, -1);
    vecs[6] = mk("unexpected_ru", 4'h1, 4'h3, 8'h09, 8'h09, 64'h6666_5555, 2, 0, 0,
                 1, 8'h01, 8'h01, 64'h5555, -1);
    vecs[7] = mk("refire", 4'h1, 4'h1, 8'h00, 8'h01, 64'h7777, 4, 0, 1,
                 1, 8'h00, 8'h01, 64'h7777, -1);
    vecs[8] = mk("backpressure", 4'h0, 4'h0, 8'h00, 8'h00, 64'h0, -1, 0, 0, 0, 8'h00, 8'h00, 64'h0, 1);

    rst = 1'b0;
    start = 1'b0;
    ru_active = '0;
    drain_valid = 1'b0;
    systolic_bottom_out = '0;
    clear_patch();
    out_if.out_ready = 1'b1;
    tick();
    tick();
    check("reset out_valid", out_if.out_valid, 0);
    check("reset out_row_data", out_if.out_row_data, 0);
    check("reset out_row_idx", out_if.out_row_idx, 0);
    check("reset out_last", out_if.out_last, 0);
    check("reset busy", busy, 0);
`ifdef BISR_MERGE_PATCH_STATS_EN
    check("reset patch_count", patch_count, 0);
`endif
    rst = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_matrix(vecs[i]);

    // Abort mid-capture, then confirm a fresh matrix still completes.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      drain_valid = 1'b1;
      systolic_bottom_out = drain_word_row(r);
      tick();
    end
    drain_valid = 1'b0;
    check("abort busy before", busy, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort out_valid", out_if.out_valid, 0);
    check("abort out_row_data", out_if.out_row_data, 0);
    check("abort out_row_idx", out_if.out_row_idx, 0);
    check("abort out_last", out_if.out_last, 0);
    check("abort busy", busy, 0);
`ifdef BISR_MERGE_PATCH_STATS_EN
    check("abort patch_count", patch_count, 0);
`endif
    patch_total = 0;
    tick();
    check("abort stays idle", busy, 0);
    run_matrix(vecs[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
